// File: rtl/serial_add_ctrl.sv
// Bit-serial ripple adder controller: loads A/B/cin, adds one bit per cycle, publishes {cout,sum}.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic [CW-1:0]    bit_cnt
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, STORE, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic               carry_q, carry_d, done_q, done_d;
  logic [WIDTH:0]     sum_q, sum_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               s_bit, c_nxt;
`ifdef SERIAL_ADD_OVF_EN
  logic               cmsb_q, cmsb_d, ovf_q, ovf_d;
`endif

  assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    cmsb_d  = cmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          // Sum bits enter at the MSB and drift down; after WIDTH steps bit i sits at index i.
          res_d   = {s_bit, res_q[WIDTH-1:1]};
          carry_d = c_nxt;
          a_d     = {1'b0, a_q[WIDTH-1:1]};
          b_d     = {1'b0, b_q[WIDTH-1:1]};
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = STORE;
`ifdef SERIAL_ADD_OVF_EN
            cmsb_d  = carry_q;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      STORE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          sum_d   = {carry_q, res_q};
          done_d  = 1'b1;
          state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = cmsb_q ^ carry_q;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q  <= cmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q == SHIFT) || (state_q == STORE);
  assign done    = done_q;
  assign sum     = sum_q;
  assign bit_cnt = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule
